// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, parity selectors and line idle level.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD       = 1'b1;
    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity bit generator for a data word, shared by TX insertion and RX checking.
// Purely combinational, zero latency; no flow control.
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; one i_clk per bit.
// Line goes low on the edge that accepts i_data_valid in IDLE; requests while busy are dropped.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    uart_state_t           state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  tx_reg, tx_nxt;
    logic                  busy_reg, busy_nxt;
    logic                  par_bit;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_reg),
        .par_bit (par_bit)
    );

    // Outputs are registered from the next state, so the line shows each bit
    // in the same cycle the FSM occupies that bit's state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tx_nxt    = UART_IDLE_LVL;
        busy_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_data_valid) begin
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                tx_nxt    = data_reg[0];
                busy_nxt  = 1'b1;
            end
            DATA: begin
                busy_nxt = 1'b1;
                if (cnt == LAST_BIT) begin
                    if (par_en_reg) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
                    end else begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    tx_nxt  = data_reg[cnt_nxt];
                end
            end
            PARITY: begin
                state_nxt = STOP;
                busy_nxt  = 1'b1;
            end
            STOP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= PAR_EVEN;
            tx_reg      <= UART_IDLE_LVL;
            busy_reg    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tx_reg   <= tx_nxt;
            busy_reg <= busy_nxt;
            if (state == IDLE && i_data_valid) begin
                data_reg    <= i_data;
                par_en_reg  <= i_par_en;
                par_typ_reg <= i_par_typ;
            end
        end
    end

    assign o_tx_out = tx_reg;
    assign o_busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of single frames plus hand sequences
// for back-to-back valid, mid-frame input changes and mid-frame reset.
module tb_uart_tx_serializer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_data_valid = 1'b0;
    logic       i_par_en = 1'b0;
    logic       i_par_typ = 1'b0;
    logic       o_tx_out;
    logic       o_busy;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_par_en     (i_par_en),
        .i_par_typ    (i_par_typ),
        .o_tx_out     (o_tx_out),
        .o_busy       (o_busy)
    );

    // exp holds the transmitted bits in order, first bit in exp[11].
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [11:0] exp;
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Entered at the negedge right after the accepting edge; checks every frame
    // bit with busy high, then the single idle cycle that follows.
    task automatic check_frame(input string nm, input logic [11:0] exp, input int len);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s tx bit%0d", nm, i), o_tx_out, exp[11 - i]);
            chk($sformatf("%s busy bit%0d", nm, i), o_busy, 1'b1);
            @(negedge i_clk);
        end
        chk($sformatf("%s idle tx", nm), o_tx_out, 1'b1);
        chk($sformatf("%s idle busy", nm), o_busy, 1'b0);
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        i_data       = d;
        i_par_en     = pe;
        i_par_typ    = pt;
        i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 12'b0101001011_00, 10};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 12'b00011110001_0, 11};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 12'b00011110011_0, 11};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 12'b01111111101_0, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 12'b01000000001_0, 11};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 12'b0000000001_00, 10};

        // Reset state, with valid asserted to show reset dominates.
        i_data_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("reset tx", o_tx_out, 1'b1);
        chk("reset busy", o_busy, 1'b0);
        i_data_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post-reset idle tx", o_tx_out, 1'b1);
        chk("post-reset idle busy", o_busy, 1'b0);

        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            check_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].len);
            @(negedge i_clk);
        end

        // Valid held high: two frames separated by exactly one idle cycle.
        i_data = 8'h55;
        i_par_en = 1'b0;
        i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data = 8'hAA;
        check_frame("b2b f1", 12'b0101010101_00, 10);
        @(negedge i_clk);
        i_data_valid = 1'b0;
        check_frame("b2b f2", 12'b0010101011_00, 10);
        @(negedge i_clk);

        // Mid-frame input changes and valid pulses (including during STOP) are ignored.
        start_frame(8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [11:0] e;
            e = 12'b0000011111_00;
            chk($sformatf("midchg tx bit%0d", i), o_tx_out, e[11 - i]);
            chk($sformatf("midchg busy bit%0d", i), o_busy, 1'b1);
            if (i == 3) begin
                i_data = 8'h0F;
                i_par_en = 1'b1;
                i_data_valid = 1'b1;
            end else if (i == 9) begin
                i_data_valid = 1'b1;
            end else begin
                i_data_valid = 1'b0;
            end
            @(negedge i_clk);
        end
        i_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midchg idle tx %0d", i), o_tx_out, 1'b1);
            chk($sformatf("midchg idle busy %0d", i), o_busy, 1'b0);
            @(negedge i_clk);
        end

        // Reset during the 5th data bit aborts the frame at once.
        start_frame(8'h00, 1'b0, 1'b0);
        repeat (5) @(negedge i_clk);
        chk("abort pre tx", o_tx_out, 1'b0);
        chk("abort pre busy", o_busy, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort tx", o_tx_out, 1'b1);
        chk("abort busy", o_busy, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort idle tx", o_tx_out, 1'b1);
        chk("abort idle busy", o_busy, 1'b0);
        start_frame(8'hA5, 1'b1, 1'b1);
        check_frame("after abort", 12'b01010010111_0, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
